// File: rtl/mcycle_seq.sv
// mcycle_seq: multi-cycle multiply/divide sequencer for the Execute stage.
// One shift-add (multiply) or restoring (divide) step per cycle, WIDTH steps
// per operation, with a registered two-word result presented in DONE.
`timescale 1ns/1ps
module mcycle_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPUTING = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result1_q, result1_d;
  logic [WIDTH-1:0] result2_q, result2_d;

  // Datapath state latched at accept time
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // negate product / quotient
  logic             neg_rem_q, neg_rem_d;   // remainder follows dividend sign
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] op1_q, op1_d;           // original dividend for divide-by-zero
  logic [WIDTH-1:0] hi_q, hi_d;             // partial product high / remainder
  logic [WIDTH-1:0] lo_q, lo_d;             // multiplier / dividend-quotient shifter
  logic [WIDTH-1:0] b_q, b_d;               // multiplicand / divisor magnitude

  // Signed views of the operands for sign extraction
  logic signed [WIDTH-1:0] op1_s;
  logic signed [WIDTH-1:0] op2_s;
  assign op1_s = Operand1;
  assign op2_s = Operand2;

  // Two's-complement magnitude of a WIDTH-bit value; -2^(WIDTH-1) maps to
  // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit value.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v,
                                                   input logic               neg);
    return neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  // Iteration step values
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH-1:0]   mul_hi, mul_lo;
  logic [WIDTH:0]     div_trial, div_diff;
  logic [WIDTH-1:0]   div_hi, div_lo;
  logic [2*WIDTH-1:0] prod;
  logic               sgn_mode, op1_neg, op2_neg;

  // Next-state, iteration step and result formation
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    result1_d  = result1_q;
    result2_d  = result2_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    op1_d      = op1_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    b_d        = b_q;

    sgn_mode = ~MCycleOp[1];
    op1_neg  = sgn_mode & (op1_s < 0);
    op2_neg  = sgn_mode & (op2_s < 0);

    // Shift-add: add multiplicand when the multiplier LSB is set, then shift
    // the {hi, lo} pair right by one.
    mul_sum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, b_q}) : {1'b0, hi_q};
    mul_hi  = mul_sum[WIDTH:1];
    mul_lo  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder and keep
    // the subtraction only when it does not go negative.
    div_trial = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_trial - {1'b0, b_q};
    div_hi    = div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
    div_lo    = {lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

    prod = negate_2w({mul_hi, mul_lo}, neg_res_q);

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          is_div_d   = MCycleOp[0];
          neg_res_d  = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          div_zero_d = (Operand2 == '0);
          op1_d      = Operand1;
          hi_d       = '0;
          lo_d       = magnitude(Operand1, op1_neg);
          b_d        = magnitude(Operand2, op2_neg);
          cnt_d      = '0;
          state_d    = S_COMPUTING;
        end
      end
      S_COMPUTING: begin
        hi_d  = is_div_q ? div_hi : mul_hi;
        lo_d  = is_div_q ? div_lo : mul_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
          if (!is_div_q) begin
            result1_d = prod[WIDTH-1:0];
            result2_d = prod[2*WIDTH-1:WIDTH];
          end else if (div_zero_q) begin
            result1_d = '1;
            result2_d = op1_q;
          end else begin
            result1_d = negate_w(div_lo, neg_res_q);
            result2_d = negate_w(div_hi, neg_rem_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and result registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      result1_q <= '0;
      result2_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result1_q <= result1_d;
      result2_q <= result2_d;
    end
  end

  // Datapath registers; meaningless outside COMPUTING, so no reset
  always_ff @(posedge CLK) begin
    is_div_q   <= is_div_d;
    neg_res_q  <= neg_res_d;
    neg_rem_q  <= neg_rem_d;
    div_zero_q <= div_zero_d;
    op1_q      <= op1_d;
    hi_q       <= hi_d;
    lo_q       <= lo_d;
    b_q        <= b_d;
  end

  assign Busy    = ~RESET & (((state_q == S_IDLE) & Start) | (state_q == S_COMPUTING));
  assign Result1 = result1_q;
  assign Result2 = result2_q;

endmodule

// File: tb/tb_mcycle_seq.sv
// Testbench for mcycle_seq: directed vector table, stall/reset corner
// sequences and randomized operations against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mcycle_seq;

  localparam int W = 32;
  localparam int BUSY_CYCLES = W + 1;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         Start;
  logic [1:0]   MCycleOp;
  logic [W-1:0] Operand1, Operand2;
  logic [W-1:0] Result1, Result2;
  logic         Busy;

  int checks = 0;
  int errors = 0;

  mcycle_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r1;
    logic [W-1:0] r2;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic from the operation definitions.
  task automatic model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r1, output logic [W-1:0] r2);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    if (op[1]) begin
      sa = {32'b0, a};
      sb = {32'b0, b};
    end else begin
      sa = {{32{a[W-1]}}, a};
      sb = {{32{b[W-1]}}, b};
    end
    if (!op[0]) begin
      p  = sa * sb;
      r1 = p[31:0];
      r2 = p[63:32];
    end else if (b == '0) begin
      r1 = '1;
      r2 = a;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      r1 = q[31:0];
      r2 = r[31:0];
    end
  endtask

  // Issue one op, hold Start until DONE, scramble inputs while busy,
  // then check stall length, results, no retrigger and result hold.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] e1, input logic [W-1:0] e2);
    int busy_cnt;
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    #1;
    chk({tag, ":busy_accept"}, 64'(Busy), 64'(1));
    busy_cnt = Busy ? 1 : 0;
    for (int i = 0; i < 200 && Busy; i++) begin
      @(negedge CLK);
      MCycleOp = 2'($urandom); Operand1 = $urandom; Operand2 = $urandom;
      #1;
      if (Busy) busy_cnt++;
    end
    chk({tag, ":busy_cycles"}, 64'(busy_cnt), 64'(BUSY_CYCLES));
    chk({tag, ":r1"}, 64'(Result1), 64'(e1));
    chk({tag, ":r2"}, 64'(Result2), 64'(e2));
    @(negedge CLK);
    Start = 1'b0;
    #1;
    chk({tag, ":busy_after_done"}, 64'(Busy), 64'(0));
    chk({tag, ":r1_hold"}, 64'(Result1), 64'(e1));
    chk({tag, ":r2_hold"}, 64'(Result2), 64'(e2));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] e1, e2, ra, rb;
    logic [1:0]   rop;

    vecs[0]  = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE};
    vecs[1]  = '{2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 32'hFFFFFFFF};
    vecs[2]  = '{2'b01, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vecs[3]  = '{2'b11, 32'h00000064, 32'h00000000, 32'hFFFFFFFF, 32'h00000064};
    vecs[4]  = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000};
    vecs[5]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000};
    vecs[6]  = '{2'b00, 32'h80000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
    vecs[7]  = '{2'b01, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[8]  = '{2'b01, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001};
    vecs[9]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{2'b10, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
    vecs[11] = '{2'b01, 32'h80000000, 32'h00000007, 32'hEDB6DB6E, 32'hFFFFFFFE};

    // Reset with Start asserted: Busy must stay low, nothing latched
    RESET = 1'b1; Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'd5; Operand2 = 32'd3;
    @(negedge CLK); #1;
    chk("reset:busy_with_start", 64'(Busy), 64'(0));
    @(negedge CLK); #1;
    chk("reset:busy_with_start2", 64'(Busy), 64'(0));
    @(negedge CLK);
    RESET = 1'b0; Start = 1'b0;
    #1;
    chk("reset:busy", 64'(Busy), 64'(0));
    chk("reset:r1", 64'(Result1), 64'(0));
    chk("reset:r2", 64'(Result2), 64'(0));
    @(negedge CLK); #1;
    chk("reset:no_latch", 64'(Busy), 64'(0));

    // Directed vectors; each new Start lands two cycles after the previous DONE
    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r1, vecs[i].r2);
    end

    // Reset pulsed while the counter is at 10
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b10; Operand1 = 32'h0000FFFF; Operand2 = 32'h00010001;
    #1;
    chk("midreset:busy_accept", 64'(Busy), 64'(1));
    for (int k = 1; k <= 11; k++) @(negedge CLK);
    #1;
    chk("midreset:busy_cnt10", 64'(Busy), 64'(1));
    RESET = 1'b1;
    #1;
    chk("midreset:busy_in_reset", 64'(Busy), 64'(0));
    @(negedge CLK);
    RESET = 1'b0; Start = 1'b0;
    #1;
    chk("midreset:busy_after", 64'(Busy), 64'(0));
    chk("midreset:r1", 64'(Result1), 64'(0));
    chk("midreset:r2", 64'(Result2), 64'(0));
    @(negedge CLK); #1;
    chk("midreset:idle", 64'(Busy), 64'(0));
    run_op("after_reset", 2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFD6, 32'hFFFFFFFF);

    // Randomized operations against the reference model
    for (int n = 0; n < 40; n++) begin
      rop = 2'($urandom);
      case ($urandom_range(0, 5))
        0:       ra = 32'h80000000;
        1:       ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFFFFFF;
        2:       rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      model(rop, ra, rb, e1, e2);
      run_op($sformatf("rand%0d_op%0d_%h_%h", n, rop, ra, rb), rop, ra, rb, e1, e2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
